colormem_arbiter: RTL and testbench
===================================

Name: colormem_arbiter

Overview:
- Shares one single-port color-lookup BRAM between the video pipeline and the host register interface.
- Each video pixel request carries two palette indices, one for playfield A and one for playfield B.
- The block sequences two back-to-back reads for every video request and delivers the aligned A/B color pair to the blend stage.
- Host reads and writes are slotted into cycles the video pipeline does not use.

Parameters:
- ADDR_W, 8, color memory address width (entries = 2**ADDR_W).
- DATA_W, 16, color word width (XRGB with alpha bits in [15:12]).

Ports:
- clk  in  1  system clock.
- reset_n_i  in  1  asynchronous active-low reset.
- vid_req_i  in  1  pixel lookup strobe; indices are sampled on the same edge.
- vid_idxA_i  in  ADDR_W  playfield A palette index.
- vid_idxB_i  in  ADDR_W  playfield B palette index.
- vid_colorA_o  out  DATA_W  looked-up A color.
- vid_colorB_o  out  DATA_W  looked-up B color.
- vid_valid_o  out  1  one-cycle pulse; A/B colors are valid.
- vid_overrun_o  out  1  one-cycle pulse; a vid_req_i was dropped.
- host_req_i  in  1  host access request; held until ack.
- host_wr_i  in  1  1 = write, 0 = read.
- host_addr_i  in  ADDR_W  host address.
- host_data_i  in  DATA_W  host write data.
- host_ack_o  out  1  one-cycle completion pulse.
- host_data_o  out  DATA_W  read data; valid with host_ack_o, held until the next read ack.
- mem_sel_o  out  1  BRAM access enable.
- mem_wr_o  out  1  BRAM write enable.
- mem_addr_o  out  ADDR_W  BRAM address.
- mem_wdata_o  out  DATA_W  BRAM write data.
- mem_rdata_i  in  DATA_W  BRAM read data; 1-cycle latency after mem_sel_o with mem_wr_o = 0.

Behaviour:
- Reset (async assert, sync release): every output 0, FSM to IDLE, capture registers, tags and host pending state cleared.
- Video FSM states: IDLE, VA, VB.
  - IDLE: vid_req_i high -> latch idxA/idxB, go to VA.
  - VA: drive mem_addr = idxA, mem_sel = 1; go to VB.
  - VB: drive mem_addr = idxB, mem_sel = 1. If vid_req_i is high this cycle, latch new indices and go to VA; otherwise go to IDLE.
  - vid_req_i high while in VA (spacing < 2 cycles): request dropped, vid_overrun_o pulses next cycle, FSM unaffected.
- Video timing, with the request sampled at edge T:
  - VA occupies cycle T+1 and VB cycle T+2.
  - A data arrives in T+2 and is captured into a hold register.
  - B data arrives in T+3.
  - vid_colorA_o, vid_colorB_o and vid_valid_o update on edge T+3, so valid is high during T+3..T+4; fixed latency 3 edges.
  - Colors hold their value between valid pulses.
- A 2-bit read-tag pipeline (NONE/VA/VB/HOST) registered alongside each mem_sel read routes mem_rdata_i to its owner.
- Host access:
  - Issued only in a cycle whose FSM state is IDLE and no host access is outstanding; video strictly has priority.
  - A vid_req_i arriving in the host issue cycle is still accepted: VA follows in the next cycle, so there is no conflict.
  - Write: mem_sel = 1, mem_wr = 1, addr/wdata from host inputs; host_ack_o pulses on the next edge.
  - Read: mem_sel = 1, mem_wr = 0; on the next edge host_data_o <= mem_rdata_i and host_ack_o pulses.
  - After ack, the block ignores host_req_i for one cycle so the host can deassert; this gives a minimum of 3 cycles per host access.
  - Host is not guaranteed progress while video requests arrive every 2 cycles; it completes in blanking. This starvation is intended.
- Write-then-read to the same address in adjacent slots returns the written value (BRAM read-after-write ordering; no bypass required).
- Reset asserted mid-sequence aborts the sequence: no valid or ack pulses occur and the BRAM sees mem_sel = 0 from reset assertion.
- mem_wdata_o is 0 whenever mem_wr_o = 0.

Decomposition:
- Put the following in xosera_pkg:
  - the state enum (IDLE/VA/VB);
  - the read-tag enum (NONE/VA/VB/HOST);
  - COLORMEM_ADDR_W and COLORMEM_DATA_W constants.
- No sub-module; FSM, tag pipeline and host slot logic live in one module.
- The BRAM itself is instantiated by the parent, alongside the blend stage.

Test Plan:
- Single vid_req with idxA = 0x12 and idxB = 0x34 (mem[0x12] = 0x8F00, mem[0x34] = 0x40F0) -> 3 edges later vid_valid_o = 1, colorA = 0x8F00, colorB = 0x40F0; mem_addr sequence 0x12 then 0x34.
- vid_req every 2 cycles for 16 pixels -> 16 valid pulses at 2-cycle spacing, colors match, host_req held throughout gets no ack until the burst ends.
- vid_req on consecutive cycles -> second request dropped, vid_overrun_o pulses once, first result still correct.
- Idle bus: host write 0x0ABC to 0x05, then host read of 0x05 -> two acks, host_data_o = 0x0ABC, each access exactly 2 cycles req-to-ack.
- Host read issued in the same cycle vid_req rises -> host ack with correct data on the next edge, video result at the normal latency, no tag mixing.
- reset_n_i pulsed low during VB -> all outputs 0 immediately, no valid pulse; post-release request behaves normally.

Source files
------------

// File: rtl/xosera_pkg.sv
// Shared types and constants for the color memory arbiter.
package xosera_pkg;

  localparam int COLORMEM_ADDR_W = 8;
  localparam int COLORMEM_DATA_W = 16;

  // Video lookup sequencer: two BRAM slots (A then B) per pixel request.
  typedef enum logic [1:0] {
    VID_IDLE = 2'd0,
    VID_VA   = 2'd1,
    VID_VB   = 2'd2
  } vid_state_t;

  // Owner of the BRAM read issued in the previous cycle.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VA   = 2'd1,
    TAG_VB   = 2'd2,
    TAG_HOST = 2'd3
  } rd_tag_t;

endpackage

// File: rtl/colormem_arbiter_if.sv
// Bus bundle between the video pipeline, host registers, color BRAM and arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface colormem_arbiter_if
  import xosera_pkg::*;
#(
  parameter int ADDR_W = COLORMEM_ADDR_W,
  parameter int DATA_W = COLORMEM_DATA_W
);

  logic              vid_req_i;
  logic [ADDR_W-1:0] vid_idxA_i;
  logic [ADDR_W-1:0] vid_idxB_i;
  logic [DATA_W-1:0] vid_colorA_o;
  logic [DATA_W-1:0] vid_colorB_o;
  logic              vid_valid_o;
  logic              vid_overrun_o;

  logic              host_req_i;
  logic              host_wr_i;
  logic [ADDR_W-1:0] host_addr_i;
  logic [DATA_W-1:0] host_data_i;
  logic              host_ack_o;
  logic [DATA_W-1:0] host_data_o;

  logic              mem_sel_o;
  logic              mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  vid_req_i, vid_idxA_i, vid_idxB_i,
    output vid_colorA_o, vid_colorB_o, vid_valid_o, vid_overrun_o,
    input  host_req_i, host_wr_i, host_addr_i, host_data_i,
    output host_ack_o, host_data_o,
    output mem_sel_o, mem_wr_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output vid_req_i, vid_idxA_i, vid_idxB_i,
    input  vid_colorA_o, vid_colorB_o, vid_valid_o, vid_overrun_o,
    output host_req_i, host_wr_i, host_addr_i, host_data_i,
    input  host_ack_o, host_data_o,
    input  mem_sel_o, mem_wr_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/colormem_arbiter.sv
// Shares the single-port color BRAM between video A/B palette lookups and
// host register accesses. Video owns the port; the host gets idle slots only.
// Reset release is expected to be synchronized to clk by the parent.
module colormem_arbiter
  import xosera_pkg::*;
#(
  parameter int ADDR_W = COLORMEM_ADDR_W,
  parameter int DATA_W = COLORMEM_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n_i,
  colormem_arbiter_if.slave   bus
);

  vid_state_t        state_q, state_d;
  rd_tag_t           tag_q, tag_d;
  logic [ADDR_W-1:0] idx_a_q, idx_b_q;
  logic [DATA_W-1:0] hold_a_q;
  logic              latch_idx;
  logic              overrun_d;
  logic              host_issue;
  logic              host_busy;
  logic              host_wr_q;

  logic              mem_sel;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] color_a_q, color_b_q;
  logic              valid_q, overrun_q;
  logic              host_ack_q;
  logic [DATA_W-1:0] host_data_q;

  // A host access is outstanding from issue until the cycle after its ack,
  // which gives the host one cycle to drop its request.
  assign host_busy = (tag_q == TAG_HOST) || host_wr_q || host_ack_q;

  // Next-state, BRAM port mux and host slot selection.
  always_comb begin
    state_d    = state_q;
    tag_d      = TAG_NONE;
    latch_idx  = 1'b0;
    overrun_d  = 1'b0;
    host_issue = 1'b0;
    mem_sel    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      VID_IDLE: begin
        if (reset_n_i && bus.host_req_i && !host_busy) begin
          host_issue = 1'b1;
          mem_sel    = 1'b1;
          mem_wr     = bus.host_wr_i;
          mem_addr   = bus.host_addr_i;
          if (bus.host_wr_i) begin
            mem_wdata = bus.host_data_i;
          end else begin
            tag_d = TAG_HOST;
          end
        end
        if (bus.vid_req_i) begin
          latch_idx = 1'b1;
          state_d   = VID_VA;
        end
      end
      VID_VA: begin
        mem_sel  = 1'b1;
        mem_addr = idx_a_q;
        tag_d    = TAG_VA;
        state_d  = VID_VB;
        if (bus.vid_req_i) begin
          overrun_d = 1'b1;
        end
      end
      VID_VB: begin
        mem_sel  = 1'b1;
        mem_addr = idx_b_q;
        tag_d    = TAG_VB;
        if (bus.vid_req_i) begin
          latch_idx = 1'b1;
          state_d   = VID_VA;
        end else begin
          state_d = VID_IDLE;
        end
      end
      default: begin
        state_d = VID_IDLE;
      end
    endcase
  end

  // Sequencer state and pixel index capture.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= VID_IDLE;
      idx_a_q <= '0;
      idx_b_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_idx) begin
        idx_a_q <= bus.vid_idxA_i;
        idx_b_q <= bus.vid_idxB_i;
      end
    end
  end

  // Read-tag pipeline: remembers who owns the data arriving next cycle.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tag_q     <= TAG_NONE;
      host_wr_q <= 1'b0;
    end else begin
      tag_q     <= tag_d;
      host_wr_q <= host_issue && bus.host_wr_i;
    end
  end

  // Video result: hold A, then present the aligned A/B pair with B.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_a_q  <= '0;
      color_a_q <= '0;
      color_b_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= (tag_q == TAG_VB);
      overrun_q <= overrun_d;
      if (tag_q == TAG_VA) begin
        hold_a_q <= bus.mem_rdata_i;
      end
      if (tag_q == TAG_VB) begin
        color_a_q <= hold_a_q;
        color_b_q <= bus.mem_rdata_i;
      end
    end
  end

  // Host completion: ack one cycle after the slot, read data held until next read.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      host_ack_q  <= 1'b0;
      host_data_q <= '0;
    end else begin
      host_ack_q <= (tag_q == TAG_HOST) || host_wr_q;
      if (tag_q == TAG_HOST) begin
        host_data_q <= bus.mem_rdata_i;
      end
    end
  end

  assign bus.mem_sel_o     = mem_sel;
  assign bus.mem_wr_o      = mem_wr;
  assign bus.mem_addr_o    = mem_addr;
  assign bus.mem_wdata_o   = mem_wdata;
  assign bus.vid_colorA_o  = color_a_q;
  assign bus.vid_colorB_o  = color_b_q;
  assign bus.vid_valid_o   = valid_q;
  assign bus.vid_overrun_o = overrun_q;
  assign bus.host_ack_o    = host_ack_q;
  assign bus.host_data_o   = host_data_q;

endmodule

// File: tb/tb_colormem_arbiter.sv
// Bench for colormem_arbiter: behavioural BRAM plus a pixel/host reference
// model based on request spacing and a shadow copy of the palette.
module tb_colormem_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  colormem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  colormem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk       (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  logic [15:0] bram     [0:255];
  logic [15:0] init_val [0:255];
  logic [15:0] shadow   [0:255];
  logic        preload;

  // Behavioural single-port BRAM with one-cycle registered read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_val[i];
    end else if (bus.mem_sel_o) begin
      if (bus.mem_wr_o) bram[bus.mem_addr_o] <= bus.mem_wdata_o;
      else              bus.mem_rdata_i      <= bram[bus.mem_addr_o];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc;
  int last_acc;
  int vcount;
  int ocount;
  logic        exp_valid [0:2047];
  logic        exp_ovr   [0:2047];
  logic [15:0] exp_a     [0:2047];
  logic [15:0] exp_b     [0:2047];
  logic [15:0] cur_a, cur_b;

  logic        host_active;
  logic        host_is_wr;
  logic [7:0]  host_a;
  logic [15:0] host_d;
  logic [15:0] host_exp;
  int          host_t0;
  int          ack_cyc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2048; i++) begin
      exp_valid[i] = 1'b0;
      exp_ovr[i]   = 1'b0;
      exp_a[i]     = '0;
      exp_b[i]     = '0;
    end
    last_acc = -100;
    cur_a    = '0;
    cur_b    = '0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid"},  32'(bus.vid_valid_o),   32'd0);
    checkOutput({tag, "_colA"},   32'(bus.vid_colorA_o),  32'd0);
    checkOutput({tag, "_colB"},   32'(bus.vid_colorB_o),  32'd0);
    checkOutput({tag, "_ovr"},    32'(bus.vid_overrun_o), 32'd0);
    checkOutput({tag, "_ack"},    32'(bus.host_ack_o),    32'd0);
    checkOutput({tag, "_hdata"},  32'(bus.host_data_o),   32'd0);
    checkOutput({tag, "_sel"},    32'(bus.mem_sel_o),     32'd0);
    checkOutput({tag, "_wr"},     32'(bus.mem_wr_o),      32'd0);
    checkOutput({tag, "_addr"},   32'(bus.mem_addr_o),    32'd0);
    checkOutput({tag, "_wdata"},  32'(bus.mem_wdata_o),   32'd0);
  endtask

  task automatic host_start(input logic wr, input logic [7:0] addr, input logic [15:0] data);
    host_active     = 1'b1;
    host_is_wr      = wr;
    host_a          = addr;
    host_d          = data;
    host_exp        = shadow[addr];
    host_t0         = cyc;
    bus.host_req_i  = 1'b1;
    bus.host_wr_i   = wr;
    bus.host_addr_i = addr;
    bus.host_data_i = data;
  endtask

  // One clock: drive video inputs, predict, then compare every output.
  task automatic applyStimulus(input logic vreq, input logic [7:0] ia, input logic [7:0] ib);
    bus.vid_req_i  = vreq;
    bus.vid_idxA_i = ia;
    bus.vid_idxB_i = ib;
    @(posedge clk);
    cyc++;
    if (vreq && rst_n) begin
      if (cyc - last_acc == 1) begin
        exp_ovr[cyc] = 1'b1;
      end else begin
        last_acc         = cyc;
        exp_valid[cyc+3] = 1'b1;
        exp_a[cyc+3]     = shadow[ia];
        exp_b[cyc+3]     = shadow[ib];
      end
    end
    #1;
    if (exp_valid[cyc]) begin
      cur_a = exp_a[cyc];
      cur_b = exp_b[cyc];
    end
    checkOutput("vid_valid", 32'(bus.vid_valid_o),   32'(exp_valid[cyc]));
    checkOutput("vid_colA",  32'(bus.vid_colorA_o),  32'(cur_a));
    checkOutput("vid_colB",  32'(bus.vid_colorB_o),  32'(cur_b));
    checkOutput("vid_ovr",   32'(bus.vid_overrun_o), 32'(exp_ovr[cyc]));
    if (!bus.mem_wr_o) checkOutput("wdata_zero", 32'(bus.mem_wdata_o), 32'd0);
    if (bus.vid_valid_o)   vcount++;
    if (bus.vid_overrun_o) ocount++;
    if (!host_active) begin
      checkOutput("host_no_ack", 32'(bus.host_ack_o), 32'd0);
    end else if (bus.host_ack_o) begin
      ack_cyc = cyc;
      if (host_is_wr) shadow[host_a] = host_d;
      else checkOutput("host_rdata", 32'(bus.host_data_o), 32'(host_exp));
      host_active    = 1'b0;
      bus.host_req_i = 1'b0;
    end
  endtask

  task automatic wait_host(input int budget);
    for (int n = 0; n < budget && host_active; n++) applyStimulus(1'b0, 8'h00, 8'h00);
    checkOutput("host_timeout", 32'(host_active), 32'd0);
    if (host_active) begin
      host_active    = 1'b0;
      bus.host_req_i = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int v0, o0;
    rst_n           = 1'b0;
    preload         = 1'b1;
    host_active     = 1'b0;
    bus.vid_req_i   = 1'b0;
    bus.vid_idxA_i  = '0;
    bus.vid_idxB_i  = '0;
    bus.host_req_i  = 1'b0;
    bus.host_wr_i   = 1'b0;
    bus.host_addr_i = '0;
    bus.host_data_i = '0;
    for (int i = 0; i < 256; i++) init_val[i] = 16'($urandom);
    init_val[8'h12] = 16'h8F00;
    init_val[8'h34] = 16'h40F0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val[i];
    clear_model();
    cyc = 0; vcount = 0; ocount = 0; ack_cyc = 0;

    // Reset state
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    preload = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Single pixel lookup
    applyStimulus(1'b1, 8'h12, 8'h34);
    checkOutput("t1_va_sel",  32'(bus.mem_sel_o),  32'd1);
    checkOutput("t1_va_addr", 32'(bus.mem_addr_o), 32'h12);
    checkOutput("t1_va_wr",   32'(bus.mem_wr_o),   32'd0);
    applyStimulus(1'b0, 8'h00, 8'h00);
    checkOutput("t1_vb_addr", 32'(bus.mem_addr_o), 32'h34);
    applyStimulus(1'b0, 8'h00, 8'h00);
    checkOutput("t1_early",   32'(bus.vid_valid_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 8'h00);
    checkOutput("t1_valid",   32'(bus.vid_valid_o),  32'd1);
    checkOutput("t1_colA",    32'(bus.vid_colorA_o), 32'h8F00);
    checkOutput("t1_colB",    32'(bus.vid_colorB_o), 32'h40F0);
    idle(2);

    // Host write then read on an idle bus
    host_start(1'b1, 8'h05, 16'h0ABC);
    #1;
    checkOutput("hw_sel",   32'(bus.mem_sel_o),   32'd1);
    checkOutput("hw_wr",    32'(bus.mem_wr_o),    32'd1);
    checkOutput("hw_addr",  32'(bus.mem_addr_o),  32'h05);
    checkOutput("hw_wdata", 32'(bus.mem_wdata_o), 32'h0ABC);
    wait_host(10);
    checkOutput("hw_latency", 32'(ack_cyc - host_t0), 32'd2);
    idle(1);
    host_start(1'b0, 8'h05, 16'h0000);
    wait_host(10);
    checkOutput("hr_latency", 32'(ack_cyc - host_t0), 32'd2);
    checkOutput("hr_data",    32'(bus.host_data_o),   32'h0ABC);
    idle(2);

    // Back-to-back requests: second one dropped
    o0 = ocount; v0 = vcount;
    applyStimulus(1'b1, 8'h12, 8'h34);
    applyStimulus(1'b1, 8'h55, 8'h66);
    checkOutput("ovr_pulse", 32'(bus.vid_overrun_o), 32'd1);
    idle(4);
    checkOutput("ovr_count",  32'(ocount - o0), 32'd1);
    checkOutput("ovr_vcount", 32'(vcount - v0), 32'd1);

    // 16-pixel burst at 2-cycle spacing with host read held throughout
    v0 = vcount;
    applyStimulus(1'b1, 8'($urandom), 8'($urandom));
    host_start(1'b0, 8'h12, 16'h0000);
    applyStimulus(1'b0, 8'h00, 8'h00);
    for (int p = 1; p < 16; p++) begin
      applyStimulus(1'b1, 8'($urandom), 8'($urandom));
      applyStimulus(1'b0, 8'h00, 8'h00);
    end
    checkOutput("burst_host_starved", 32'(host_active), 32'd1);
    wait_host(10);
    idle(3);
    checkOutput("burst_vcount", 32'(vcount - v0), 32'd16);

    // Host read issued in the same cycle a pixel request arrives
    host_start(1'b0, 8'h34, 16'h0000);
    applyStimulus(1'b1, 8'h05, 8'h12);
    wait_host(10);
    checkOutput("mix_latency", 32'(ack_cyc - host_t0), 32'd2);
    checkOutput("mix_hdata",   32'(bus.host_data_o),   32'h40F0);
    idle(3);
    checkOutput("mix_colA", 32'(bus.vid_colorA_o), 32'h0ABC);
    checkOutput("mix_colB", 32'(bus.vid_colorB_o), 32'h8F00);

    // Randomized mix of pixel requests and host reads
    for (int n = 0; n < 300; n++) begin
      if (!host_active && $urandom_range(0, 9) == 0) host_start(1'b0, 8'($urandom), 16'h0000);
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
    idle(3);
    wait_host(40);
    idle(3);

    // Reset asserted during VB aborts the pixel
    v0 = vcount;
    applyStimulus(1'b1, 8'h12, 8'h34);
    applyStimulus(1'b0, 8'h00, 8'h00);
    bus.host_req_i = 1'b1;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_all_zero("midrst");
    idle(3);
    bus.host_req_i = 1'b0;
    rst_n = 1'b1;
    idle(3);
    checkOutput("midrst_novalid", 32'(vcount - v0), 32'd0);
    applyStimulus(1'b1, 8'h34, 8'h12);
    idle(3);
    checkOutput("postrst_colA", 32'(bus.vid_colorA_o), 32'h40F0);
    checkOutput("postrst_colB", 32'(bus.vid_colorB_o), 32'h8F00);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
